rip_csr_unit: RTL and testbench

- Stateful CSR execution unit in the execute/writeback boundary of the RIP core.
- Holds the machine CSR state: mtvec, mepc, mcause, cycle, and the branch-prediction counters bptp/bptn/bpfp/bpfn.
- Executes CSRRW/CSRRS/CSRRC accesses and records trap entry.
- Produces the PC redirect for exceptions and MRET, and counts cycles and branch-prediction outcomes.

---
 rtl/rip_csr_unit.sv | 119 +++++++++++
 tb/tb_rip_csr_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rip_csr_unit.sv
// rip_csr_unit: machine CSR state, CSR read/modify/write, trap/MRET redirect, cycle and branch-prediction counters
module rip_csr_unit #(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
   parameter int          COUNT_W     = 32
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        csr_valid,
   input  logic [1:0]  csr_op,
   input  logic [11:0] csr_num,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   input  logic        trap_valid,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   input  logic        mret_valid,
   input  logic        bp_valid,
   input  logic        bp_pred,
   input  logic        bp_taken,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);
   localparam logic [11:0] MTVEC  = 12'h305;
   localparam logic [11:0] MEPC   = 12'h341;
   localparam logic [11:0] MCAUSE = 12'h342;
   localparam logic [11:0] CYCLE  = 12'hC00;
   localparam logic [11:0] BPTP   = 12'hCC0;
   localparam logic [11:0] BPTN   = 12'hCC1;
   localparam logic [11:0] BPFP   = 12'hCC2;
   localparam logic [11:0] BPFN   = 12'hCC3;
   localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

   logic [31:0]        mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
   logic [COUNT_W-1:0] cycle_q, cycle_d, bptp_q, bptp_d, bptn_q, bptn_d;
   logic [COUNT_W-1:0] bpfp_q, bpfp_d, bpfn_q, bpfn_d;
   logic               redirect_valid_q, redirect_valid_d;
   logic [31:0]        redirect_pc_q, redirect_pc_d;
   logic [31:0]        wval;
   logic               wen;

   // read decode of the current (pre-edge) state, counters zero-extended
   always_comb begin
      case (csr_num)
         MTVEC:   csr_rdata = mtvec_q;
         MEPC:    csr_rdata = mepc_q;
         MCAUSE:  csr_rdata = mcause_q;
         CYCLE:   csr_rdata = 32'(cycle_q);
         BPTP:    csr_rdata = 32'(bptp_q);
         BPTN:    csr_rdata = 32'(bptn_q);
         BPFP:    csr_rdata = 32'(bpfp_q);
         BPFN:    csr_rdata = 32'(bpfn_q);
         default: csr_rdata = 32'h0;
      endcase
   end

   // new CSR value from the old one; a trap or MRET in the same cycle drops the write
   always_comb begin
      wval = csr_op == 2'b01 ? csr_wdata :
             csr_op == 2'b10 ? (csr_rdata | csr_wdata) : (csr_rdata & ~csr_wdata);
      wen  = csr_valid && csr_op != 2'b00 && !trap_valid && !mret_valid;
   end

   // next state: counters always run, then trap > MRET > CSR write
   always_comb begin
      mtvec_d          = mtvec_q;
      mepc_d           = mepc_q;
      mcause_d         = mcause_q;
      cycle_d          = cycle_q + ONE;
      bptp_d           = bptp_q;
      bptn_d           = bptn_q;
      bpfp_d           = bpfp_q;
      bpfn_d           = bpfn_q;
      redirect_valid_d = trap_valid || mret_valid;
      redirect_pc_d    = trap_valid ? mtvec_q : mret_valid ? mepc_q : redirect_pc_q;
      if (bp_valid) begin
         if (bp_pred && bp_taken)   bptp_d = bptp_q + ONE;
         if (!bp_pred && !bp_taken) bptn_d = bptn_q + ONE;
         if (bp_pred && !bp_taken)  bpfp_d = bpfp_q + ONE;
         if (!bp_pred && bp_taken)  bpfn_d = bpfn_q + ONE;
      end
      if (trap_valid) begin
         mepc_d   = trap_pc & ~32'd3;
         mcause_d = trap_cause;
      end
      if (wen && csr_num == MTVEC)  mtvec_d  = wval & ~32'd3;
      if (wen && csr_num == MEPC)   mepc_d   = wval & ~32'd3;
      if (wen && csr_num == MCAUSE) mcause_d = wval;
   end

   // state registers, asynchronously cleared
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mtvec_q          <= RESET_MTVEC & ~32'd3;
         mepc_q           <= '0;
         mcause_q         <= '0;
         cycle_q          <= '0;
         bptp_q           <= '0;
         bptn_q           <= '0;
         bpfp_q           <= '0;
         bpfn_q           <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         mtvec_q          <= mtvec_d;
         mepc_q           <= mepc_d;
         mcause_q         <= mcause_d;
         cycle_q          <= cycle_d;
         bptp_q           <= bptp_d;
         bptn_q           <= bptn_d;
         bpfp_q           <= bpfp_d;
         bpfn_q           <= bpfn_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
endmodule

// File: tb/tb_rip_csr_unit.sv
// tb_rip_csr_unit: directed stimulus with a behavioural CSR model checked every cycle plus literal spot checks
module tb_rip_csr_unit;
   localparam logic [11:0] A_MTVEC = 12'h305, A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_CYCLE = 12'hC00;
   localparam logic [11:0] A_BPTP = 12'hCC0, A_BPTN = 12'hCC1, A_BPFP = 12'hCC2, A_BPFN = 12'hCC3;
   localparam logic [31:0] RST_TVEC = 32'h0000_1003;

   logic        clk = 0, rstn = 0;
   logic        csr_valid = 0, trap_valid = 0, mret_valid = 0, bp_valid = 0, bp_pred = 0, bp_taken = 0;
   logic [1:0]  csr_op = 0;
   logic [11:0] csr_num = A_MTVEC;
   logic [31:0] csr_wdata = 0, trap_pc = 0, trap_cause = 0;
   logic [31:0] csr_rdata, redirect_pc, w_rdata, w_rpc;
   logic        redirect_valid, w_rv;
   logic        z = 0;
   logic [1:0]  z2 = 0;
   logic [31:0] z32 = 0;
   logic [11:0] w_num = A_CYCLE;
   int          checks = 0, errors = 0;

   // behavioural model state
   logic [31:0] m_tvec, m_epc, m_cause, m_cyc, old_v, new_v;
   logic [31:0] m_bp [4];
   logic        m_rv;
   logic [31:0] m_rpc;
   logic [2:0]  m_wcyc;

   always #5 clk = ~clk;

   rip_csr_unit #(.RESET_MTVEC(RST_TVEC), .COUNT_W(32)) dut (
      .clk(clk), .rstn(rstn), .csr_valid(csr_valid), .csr_op(csr_op), .csr_num(csr_num),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .trap_valid(trap_valid), .trap_pc(trap_pc),
      .trap_cause(trap_cause), .mret_valid(mret_valid), .bp_valid(bp_valid), .bp_pred(bp_pred),
      .bp_taken(bp_taken), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

   rip_csr_unit #(.RESET_MTVEC(32'h0), .COUNT_W(3)) dut_w (
      .clk(clk), .rstn(rstn), .csr_valid(z), .csr_op(z2), .csr_num(w_num),
      .csr_wdata(z32), .csr_rdata(w_rdata), .trap_valid(z), .trap_pc(z32),
      .trap_cause(z32), .mret_valid(z), .bp_valid(z), .bp_pred(z),
      .bp_taken(z), .redirect_valid(w_rv), .redirect_pc(w_rpc));

   function automatic logic [31:0] m_read(input logic [11:0] n);
      case (n)
         A_MTVEC:  return m_tvec;
         A_MEPC:   return m_epc;
         A_MCAUSE: return m_cause;
         A_CYCLE:  return m_cyc;
         A_BPTP:   return m_bp[0];
         A_BPTN:   return m_bp[1];
         A_BPFP:   return m_bp[2];
         A_BPFN:   return m_bp[3];
         default:  return 32'h0;
      endcase
   endfunction

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [11:0] n, input logic [31:0] exp, input string name);
      logic [11:0] s;
      s = csr_num;
      csr_num = n;
      #1 check(name, csr_rdata, exp);
      csr_num = s;
   endtask

   // model: apply one clock of architectural rules, reset clears immediately
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_tvec = RST_TVEC & ~32'd3; m_epc = 0; m_cause = 0; m_cyc = 0;
         for (int i = 0; i < 4; i++) m_bp[i] = 0;
         m_rv = 0; m_rpc = 0; m_wcyc = 0;
      end else begin
         old_v = m_read(csr_num);
         new_v = csr_op == 2'd1 ? csr_wdata : csr_op == 2'd2 ? (old_v | csr_wdata) : (old_v & ~csr_wdata);
         m_cyc = m_cyc + 1;
         m_wcyc = m_wcyc + 1;
         if (bp_valid) begin
            if (bp_pred) m_bp[bp_taken ? 0 : 2] = m_bp[bp_taken ? 0 : 2] + 1;
            else         m_bp[bp_taken ? 3 : 1] = m_bp[bp_taken ? 3 : 1] + 1;
         end
         if (trap_valid) begin
            m_rv = 1; m_rpc = m_tvec; m_epc = trap_pc & ~32'd3; m_cause = trap_cause;
         end else if (mret_valid) begin
            m_rv = 1; m_rpc = m_epc;
         end else begin
            m_rv = 0;
            if (csr_valid && csr_op != 2'd0) begin
               if (csr_num == A_MTVEC)  m_tvec  = new_v & ~32'd3;
               if (csr_num == A_MEPC)   m_epc   = new_v & ~32'd3;
               if (csr_num == A_MCAUSE) m_cause = new_v;
            end
         end
      end
   end

   // compare DUT against the model every cycle, away from the active edge
   always @(negedge clk) begin
      check("rdata", csr_rdata, m_read(csr_num));
      check("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_rv});
      if (m_rv) check("redirect_pc", redirect_pc, m_rpc);
      check("wrap_cycle", w_rdata, {29'b0, m_wcyc});
      check("wrap_rv", {31'b0, w_rv}, 32'h0);
   end

   bit pv [5] = '{1, 0, 1, 0, 1};
   bit tv [5] = '{1, 0, 0, 1, 1};

   initial begin
      repeat (3) tick;
      check("reset_rpc", redirect_pc, 32'h0);
      rstn = 1;
      repeat (5) tick;
      csr_num = A_CYCLE;
      #1 check("idle_cycle", csr_rdata, 32'd5);
      check("idle_rv", {31'b0, redirect_valid}, 32'h0);
      csr_num = A_MTVEC;
      #1 check("reset_mtvec", csr_rdata, 32'h0000_1000);
      csr_valid = 1; csr_op = 2'd1; csr_wdata = 32'h8000_0103;
      tick;
      check("rw_mtvec", csr_rdata, 32'h8000_0100);
      csr_op = 2'd2; csr_wdata = 32'h10;
      tick;
      check("rs_mtvec", csr_rdata, 32'h8000_0110);
      csr_op = 2'd3; csr_wdata = 32'h8000_0000;
      tick;
      csr_valid = 0;
      check("rc_mtvec", csr_rdata, 32'h0000_0110);
      check("wrap_zero", w_rdata, 32'h0);
      rd(A_CYCLE, 32'd8, "cycle8");
      trap_valid = 1; trap_pc = 32'h42; trap_cause = 32'h2;
      csr_valid = 1; csr_op = 2'd1; csr_wdata = 32'hFFFF_FFFF;
      tick;
      trap_valid = 0; csr_valid = 0;
      check("trap_rv", {31'b0, redirect_valid}, 32'h1);
      check("trap_rpc", redirect_pc, 32'h110);
      rd(A_MEPC, 32'h40, "trap_mepc");
      rd(A_MCAUSE, 32'h2, "trap_mcause");
      rd(A_MTVEC, 32'h110, "trap_mtvec_kept");
      tick;
      check("trap_pulse_end", {31'b0, redirect_valid}, 32'h0);
      mret_valid = 1;
      tick;
      mret_valid = 0;
      check("mret_rpc", redirect_pc, 32'h40);
      tick;
      check("mret_pulse_end", {31'b0, redirect_valid}, 32'h0);
      trap_valid = 1; trap_pc = 32'h1237; trap_cause = 32'h5;
      tick;
      trap_valid = 0; mret_valid = 1;
      check("b2b_trap_rpc", redirect_pc, 32'h110);
      tick;
      check("b2b_mret_rv", {31'b0, redirect_valid}, 32'h1);
      check("b2b_mret_rpc", redirect_pc, 32'h1234);
      csr_valid = 1; csr_op = 2'd1; csr_num = A_MEPC; csr_wdata = 32'h888;
      tick;
      mret_valid = 0; csr_valid = 0;
      check("mret_over_write", csr_rdata, 32'h1234);
      csr_valid = 1; csr_wdata = 32'h503;
      tick;
      check("mepc_align", csr_rdata, 32'h500);
      csr_op = 2'd2; csr_num = A_MCAUSE; csr_wdata = 32'h8000_0000;
      tick;
      csr_valid = 0;
      check("mcause_rs", csr_rdata, 32'h8000_0005);
      for (int i = 0; i < 5; i++) begin
         bp_valid = 1; bp_pred = pv[i]; bp_taken = tv[i];
         if (i == 2) begin trap_valid = 1; trap_pc = 32'h80; trap_cause = 32'h3; end
         tick;
         trap_valid = 0;
         if (i == 2) check("bp_trap_rpc", redirect_pc, 32'h110);
      end
      bp_valid = 0;
      rd(A_BPTP, 32'd2, "bptp");
      rd(A_BPTN, 32'd1, "bptn");
      tick;
      rd(A_BPFP, 32'd1, "bpfp");
      rd(A_BPFN, 32'd1, "bpfn");
      csr_valid = 1; csr_op = 2'd1; csr_num = A_BPTP; csr_wdata = 32'h55;
      tick;
      csr_valid = 0;
      check("bptp_ro", csr_rdata, 32'd2);
      csr_num = 12'h7FF;
      #1 check("unknown_rd", csr_rdata, 32'h0);
      csr_valid = 1; csr_wdata = 32'hFFFF_FFFF;
      tick;
      csr_valid = 0;
      check("unknown_wr", csr_rdata, 32'h0);
      rd(A_MTVEC, 32'h110, "unk_mtvec");
      rd(A_MEPC, 32'h80, "unk_mepc");
      rd(A_MCAUSE, 32'h3, "unk_mcause");
      bp_valid = 1; bp_pred = 1; bp_taken = 1;
      trap_valid = 1; trap_pc = 32'h100; trap_cause = 32'h7;
      tick;
      trap_valid = 0;
      check("pre_rst_rv", {31'b0, redirect_valid}, 32'h1);
      csr_valid = 1; csr_op = 2'd1; csr_num = A_MCAUSE; csr_wdata = 32'h77;
      #1 rstn = 0;
      #1 check("rst_rv", {31'b0, redirect_valid}, 32'h0);
      check("rst_rpc", redirect_pc, 32'h0);
      rd(A_BPTP, 32'h0, "rst_bptp");
      tick;
      tick;
      rstn = 1; bp_valid = 0; csr_valid = 0;
      rd(A_BPTP, 32'h0, "rst_bptp2");
      rd(A_BPFP, 32'h0, "rst_bpfp");
      rd(A_MCAUSE, 32'h0, "rst_mcause");
      tick;
      rd(A_MTVEC, 32'h1000, "rst_mtvec");
      rd(A_MEPC, 32'h0, "rst_mepc");
      repeat (12) tick;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
